// File: rtl/rst_seq_if.sv
// Reset sequencer bus: warm-reset request in, per-channel resets and status out.
// The sequencer uses the slave modport; whoever requests warm resets uses master.
interface rst_seq_if #(
    parameter int NUM_CH = 8
);
    logic              soft_rst_req;
    logic [NUM_CH-1:0] rst_out;
    logic              done;
    logic [1:0]        state;
    logic [7:0]        warm_cnt;
    logic [7:0]        debug;

    modport master (output soft_rst_req, input rst_out, done, state, warm_cnt, debug);
    modport slave  (input soft_rst_req, output rst_out, done, state, warm_cnt, debug);
endinterface

// File: rtl/rst_seq.sv
// rst_seq: multi-channel reset sequencer.
// This block does four things:
//   - holds all channels for COLD_CYCLES after sys_rst_n is released;
//   - releases the channels one by one, STAGGER cycles apart, bit 0 first;
//   - accepts warm resets (soft_rst_req) in RELEASE/RUN and re-runs the sequence
//     with a HOLD_CYCLES hold;
//   - keeps a count of accepted warm resets that saturates at 255.
// Optional macro RST_SEQ_HEARTBEAT_EN: debug shows the top byte of a free-running
// heartbeat counter instead of the status snapshot.
module rst_seq #(
    parameter int NUM_CH      = 8,
    parameter int COLD_CYCLES = 16383,
    parameter int HOLD_CYCLES = 256,
    parameter int STAGGER     = 16,
    parameter int CNT_W       = 14,
    parameter int HB_W        = 32
) (
    input  logic    clk,
    input  logic    sys_rst_n,
    rst_seq_if.slave bus
);
    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    localparam int KW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] COLD_LAST = CNT_W'(COLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
    localparam logic [KW-1:0]    K_LAST    = KW'(NUM_CH - 1);

    logic [1:0]        r_sync;
    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [KW-1:0]     r_k;
    logic [NUM_CH-1:0] r_rst;
    logic              r_done;
    logic [7:0]        r_warm;
    logic [7:0]        r_dbg;
    logic              w_accept;
    logic              w_hold_end;

    // Warm requests only count once some channel is (or is about to be) out of reset.
    assign w_accept   = bus.soft_rst_req && (r_state == ST_RELEASE || r_state == ST_RUN);
    assign w_hold_end = (r_state == ST_ASSERT) ? (r_cnt == COLD_LAST) : (r_cnt == HOLD_LAST);

    // The flops assert asynchronously and release through two flops. This gives a clean first counting edge.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_sync <= 2'b00;
        else            r_sync <= {r_sync[0], 1'b1};
    end

    // Sequencer: the async reset sets the reset values, and everything stays frozen until the synchroniser releases.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= ST_ASSERT;
            r_cnt   <= '0;
            r_k     <= KW'(1);
            r_rst   <= '1;
            r_done  <= 1'b0;
            r_warm  <= 8'd0;
        end else if (r_sync[1]) begin
            if (w_accept) begin
                r_state <= ST_HOLD;
                r_cnt   <= '0;
                r_k     <= KW'(1);
                r_rst   <= '1;
                r_done  <= 1'b0;
                if (r_warm != 8'hFF) r_warm <= r_warm + 8'd1;
            end else begin
                case (r_state)
                    ST_ASSERT, ST_HOLD: begin
                        if (w_hold_end) begin
                            r_cnt    <= '0;
                            r_rst[0] <= 1'b0;
                            r_k      <= KW'(1);
                            if (NUM_CH == 1) begin
                                r_state <= ST_RUN;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_RELEASE;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    ST_RELEASE: begin
                        if (r_cnt == STAG_LAST) begin
                            r_cnt <= '0;
                            r_k   <= r_k + KW'(1);
                            for (int i = 0; i < NUM_CH; i++)
                                if (r_k == KW'(i)) r_rst[i] <= 1'b0;
                            if (r_k == K_LAST) begin
                                r_done  <= 1'b1;
                                r_state <= ST_RUN;
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef RST_SEQ_HEARTBEAT_EN
    logic [HB_W-1:0] r_hb;

    // A free-running heartbeat that only sys_rst_n clears. Warm resets do not touch it.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_hb <= '0;
        else            r_hb <= r_hb + HB_W'(1);
    end

    assign r_dbg = r_hb[HB_W-1 -: 8];
`else
    // A registered status snapshot. It lags the live status by one cycle. It reads 0 while in reset.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_dbg <= 8'd0;
        else            r_dbg <= {r_warm[2:0], r_done, r_state, r_rst[0], bus.soft_rst_req};
    end
`endif

    assign bus.rst_out  = r_rst;
    assign bus.done     = r_done;
    assign bus.state    = r_state;
    assign bus.warm_cnt = r_warm;
    assign bus.debug    = r_dbg;
endmodule

// File: tb/tb_rst_seq.sv
// Testbench for rst_seq. A timeline model predicts every output from the number of
// edges since the last cold or warm start. Directed checks with literal values pin
// the model to the hand-computed edge numbers.
module tb_rst_seq;
    localparam int N    = 4;
    localparam int COLD = 10;
    localparam int HOLD = 5;
    localparam int STG  = 4;

    logic clk = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 clk = ~clk;

    rst_seq_if #(.NUM_CH(N)) bus ();
    rst_seq_if #(.NUM_CH(1)) bus1 ();

    rst_seq #(.NUM_CH(N), .COLD_CYCLES(COLD), .HOLD_CYCLES(HOLD), .STAGGER(STG),
              .CNT_W(8), .HB_W(32))
        dut (.clk(clk), .sys_rst_n(sys_rst_n), .bus(bus.slave));

    rst_seq #(.NUM_CH(1), .COLD_CYCLES(3), .HOLD_CYCLES(2), .STAGGER(1),
              .CNT_W(4), .HB_W(16))
        dut1 (.clk(clk), .sys_rst_n(sys_rst_n), .bus(bus1.slave));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- timeline model ----------------
    // since = number of edges after the reference edge. The reference edge is the 2nd edge after
    // sys_rst_n rises, or the warm-accept edge. Channel k is free once since >= hold + k*STG.
    int          since;
    bit          cold;
    int          warm_m;
    logic [7:0]  dbg_m;
    logic [31:0] hb_m;

    function automatic int m_len();
        return cold ? COLD : HOLD;
    endfunction

    function automatic logic [N-1:0] m_rst();
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = (since < m_len() + k * STG);
        return r;
    endfunction

    function automatic bit m_done();
        return since >= m_len() + (N - 1) * STG;
    endfunction

    function automatic logic [1:0] m_state();
        if (since < m_len()) return cold ? 2'd0 : 2'd3;
        if (m_done())        return 2'd2;
        return 2'd1;
    endfunction

    always @(posedge clk or negedge sys_rst_n) begin
        logic [1:0]   st;
        logic [N-1:0] r;
        logic [7:0]   w;
        if (!sys_rst_n) begin
            since  = -2;
            cold   = 1'b1;
            warm_m = 0;
            dbg_m  = 8'd0;
            hb_m   = 32'd0;
        end else begin
            st    = m_state();
            r     = m_rst();
            w     = 8'(warm_m);
            dbg_m = {w[2:0], m_done(), st, r[0], bus.soft_rst_req};
            hb_m  = hb_m + 32'd1;
            if (bus.soft_rst_req && (st == 2'd1 || st == 2'd2)) begin
                since = 0;
                cold  = 1'b0;
                if (warm_m < 255) warm_m++;
            end else begin
                since++;
            end
        end
    end

    // The compare process checks the model against the DUT on every cycle.
    always @(posedge clk) begin
        #1;
        chk("m_rst_out",  32'(bus.rst_out),  32'(m_rst()));
        chk("m_done",     32'(bus.done),     32'(m_done()));
        chk("m_state",    32'(bus.state),    32'(m_state()));
        chk("m_warm_cnt", 32'(bus.warm_cnt), 32'(warm_m));
`ifdef RST_SEQ_HEARTBEAT_EN
        chk("m_debug",    32'(bus.debug),    32'(hb_m[31:24]));
`else
        chk("m_debug",    32'(bus.debug),    32'(dbg_m));
`endif
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [3:0] r, input logic d,
                       input logic [1:0] s, input logic [7:0] w);
        chk({nm, "_rst"},   32'(bus.rst_out),  32'(r));
        chk({nm, "_done"},  32'(bus.done),     32'(d));
        chk({nm, "_state"}, 32'(bus.state),    32'(s));
        chk({nm, "_warm"},  32'(bus.warm_cnt), 32'(w));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        bus.soft_rst_req  = 1'b0;
        bus1.soft_rst_req = 1'b0;
        step(3);
        lit("reset", 4'hF, 1'b0, 2'd0, 8'd0);
        chk("reset_debug", 32'(bus.debug), 32'd0);
        sys_rst_n = 1'b1;                       // the next edge is edge 1

        step(4);                                // edge 4
        chk("ch1_e4_rst",   32'(bus1.rst_out), 32'd1);
        chk("ch1_e4_state", 32'(bus1.state),   32'd0);
        step(1);                                // edge 5 = 2 + COLD(3)
        chk("ch1_e5_rst",   32'(bus1.rst_out), 32'd0);
        chk("ch1_e5_done",  32'(bus1.done),    32'd1);
        chk("ch1_e5_state", 32'(bus1.state),   32'd2);
        bus.soft_rst_req = 1'b1;                // this request arrives in ASSERT and is ignored
        step(1);                                // edge 6
        bus.soft_rst_req = 1'b0;
        lit("assert_req", 4'hF, 1'b0, 2'd0, 8'd0);
        step(5);  lit("e11", 4'hF, 1'b0, 2'd0, 8'd0);
        step(1);  lit("e12", 4'hE, 1'b0, 2'd1, 8'd0);
        step(4);  lit("e16", 4'hC, 1'b0, 2'd1, 8'd0);
        step(4);  lit("e20", 4'h8, 1'b0, 2'd1, 8'd0);
        step(3);  lit("e23", 4'h8, 1'b0, 2'd1, 8'd0);
        step(1);  lit("e24", 4'h0, 1'b1, 2'd2, 8'd0);

        bus.soft_rst_req = 1'b1;                // warm reset from RUN
        step(1);  lit("warm_acc", 4'hF, 1'b0, 2'd3, 8'd1);   // edge 25
        bus.soft_rst_req = 1'b0;
        step(1);
        bus.soft_rst_req = 1'b1;                // this request arrives in HOLD and is ignored
        step(1);
        bus.soft_rst_req = 1'b0;
        step(2);  lit("hold_e29", 4'hF, 1'b0, 2'd3, 8'd1);
        step(1);  lit("hold_e30", 4'hE, 1'b0, 2'd1, 8'd1);
        step(4);  lit("hold_e34", 4'hC, 1'b0, 2'd1, 8'd1);
        bus.soft_rst_req = 1'b1;                // this request arrives in RELEASE after ch1 is freed
        step(1);  lit("rel_acc", 4'hF, 1'b0, 2'd3, 8'd2);
        bus.soft_rst_req = 1'b0;
        step(5);  lit("rel_e40", 4'hE, 1'b0, 2'd1, 8'd2);
        step(1);
        sys_rst_n = 1'b0;                       // drop the reset mid-RELEASE, between edges
        #1;
        lit("async", 4'hF, 1'b0, 2'd0, 8'd0);
        step(2);
        sys_rst_n = 1'b1;
        step(11); lit("cold2_e11", 4'hF, 1'b0, 2'd0, 8'd0);
        step(1);  lit("cold2_e12", 4'hE, 1'b0, 2'd1, 8'd0);
        step(12); lit("cold2_e24", 4'h0, 1'b1, 2'd2, 8'd0);

        bus.soft_rst_req = 1'b1;                // a held level request re-triggers every 6 edges
        step(2000);
        chk("sat_warm", 32'(bus.warm_cnt), 32'd255);
        bus.soft_rst_req = 1'b0;
        step(40); lit("sat_run", 4'h0, 1'b1, 2'd2, 8'd255);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/rst_seq.md
Name: rst_seq

Overview:
Parametrised core reset sequencer. It generalises the fixed single-output cold-reset counter used at board top level into a multi-channel block. Power-on/cold hold time is configurable, per-channel staggered release is added, and software-requested warm reset is supported. Sits at board top level and drives the reset inputs of eth_top, db_top and future subsystems from one clock domain.

Parameters:
NUM_CH, 8, number of reset output channels (1..32)
COLD_CYCLES, 16383, cycles all channels are held after async reset release
HOLD_CYCLES, 256, cycles all channels are held on a warm reset
STAGGER, 16, cycles between successive channel releases (>=1)
CNT_W, 14, internal counter width; must hold max(COLD_CYCLES, HOLD_CYCLES, STAGGER)
HB_W, 32, heartbeat counter width (>=8)

Ports:
clk  input  1  sequencer clock (clk200 / clk100 domain)
sys_rst_n  input  1  asynchronous, active-low reset
soft_rst_req  input  1  warm reset request, level-sampled each cycle
rst_out  output  NUM_CH  active-high per-channel resets; bit 0 is released first
done  output  1  high when all channels are released
state  output  2  FSM state: 0 ASSERT, 1 RELEASE, 2 RUN, 3 HOLD
warm_cnt  output  8  number of accepted warm resets, saturating
debug  output  8  LED debug bus

Behaviour:
- One clock. Reset is asynchronous and active-low: sys_rst_n low immediately forces rst_out all 1s, done 0, state ASSERT, counters 0, warm_cnt 0, debug 0.
- Release of sys_rst_n passes through a 2-flop synchroniser. The internal reset clears on the 2nd rising edge after sys_rst_n rises; internal cnt=0 at that edge.
- ASSERT: cnt increments each cycle. On the edge where cnt==COLD_CYCLES-1: rst_out[0]<=0, cnt<=0, go RELEASE. If NUM_CH==1, go straight to RUN with done<=1 instead.
- RELEASE: ch index k starts at 1. cnt increments each cycle. On the edge where cnt==STAGGER-1: rst_out[k]<=0, cnt<=0, k++. The edge that clears rst_out[NUM_CH-1] also sets done<=1 and goes RUN.
- Net timing: rst_out[k] falls on rising edge 2+COLD_CYCLES+k*STAGGER after sys_rst_n rises. done rises together with the last channel.
- RUN: outputs are stable; counters are idle.
- soft_rst_req is accepted only in RUN or RELEASE. On the accepting edge: rst_out<=all 1s, done<=0, cnt<=0, k<=1, warm_cnt increments (saturating at 255), go HOLD.
- soft_rst_req is ignored in ASSERT and HOLD; the request is not queued.
- HOLD: same as ASSERT but uses HOLD_CYCLES. rst_out[0] is released HOLD_CYCLES edges after the accepting edge, then the RELEASE sequence runs as above.
- A request held high continuously in RUN re-triggers on the first cycle back in RELEASE. This is intended: a level request keeps the system in reset.
- Released rst_out bits never re-assert except through HOLD or sys_rst_n.
- Counter arithmetic is unsigned CNT_W bits. Compares use the parameter minus 1, so COLD_CYCLES/HOLD_CYCLES of 1 give a single-cycle hold.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
Macro: RST_SEQ_HEARTBEAT_EN
- Defined: free-running HB_W-bit heartbeat counter, cleared only by sys_rst_n. debug = hb_cnt[HB_W-1:HB_W-8]. This replaces the ad-hoc LED clock-check counter.
- Undefined: no heartbeat counter. debug = {warm_cnt[2:0], done, state, rst_out[0], soft_rst_req registered}. Bit order is MSB to LSB as listed.

Test Plan:
- NUM_CH=4, COLD=10, STAGGER=4; release sys_rst_n -> rst_out[0..3] fall at edges 12/16/20/24; done=1 and state=2 at edge 24.
- After RUN, pulse soft_rst_req for 1 cycle with HOLD=5 -> next edge rst_out=4'hF, done=0, state=3, warm_cnt=1. rst_out[0] falls 5 edges after the accepting edge, then the 4-edge stagger repeats.
- soft_rst_req pulsed during ASSERT and during HOLD -> no effect: timing unchanged, warm_cnt unchanged.
- soft_rst_req during RELEASE after rst_out[1] has fallen -> all channels reassert next edge, state=3.
- sys_rst_n dropped mid-RELEASE -> rst_out=all 1s and done=0 asynchronously (before the next edge). The full cold sequence repeats after release.
- 300 accepted warm resets -> warm_cnt saturates at 255. NUM_CH=1 -> ASSERT goes straight to RUN at edge 2+COLD. With the macro defined, debug toggles MSB every 2^(HB_W-1) cycles, independent of soft resets.
